// File: rtl/mem_router_if.sv
// mem_router_if: bundles the master-side request/response bus and the
// shared slave-side bus of mem_router.
//   slave  modport : view taken by the router (accepts master requests,
//                    drives responses and the per-slave request strobes)
//   master modport : view taken by the surrounding system (arbiter output
//                    plus the slave devices)
// Signals:
//   master_valid/instr/addr/wdata/wstrb  request from the arbiter
//   master_rdata/ready/error             response to the arbiter
//   master_busy                          skid buffer occupied
//   overflow                             sticky request-dropped flag
//   slave_valid                          one-hot request strobes
//   slave_instr/addr/wdata/wstrb         shared request fields (rebased addr)
//   slave_rdata/ready                    flattened responses from slaves
interface mem_router_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                             master_valid;
  logic                             master_instr;
  logic [ADDR_WIDTH-1:0]            master_addr;
  logic [DATA_WIDTH-1:0]            master_wdata;
  logic [DATA_WIDTH/8-1:0]          master_wstrb;
  logic [DATA_WIDTH-1:0]            master_rdata;
  logic                             master_ready;
  logic                             master_error;
  logic                             master_busy;
  logic                             overflow;
  logic [NUM_SLAVES-1:0]            slave_valid;
  logic                             slave_instr;
  logic [ADDR_WIDTH-1:0]            slave_addr;
  logic [DATA_WIDTH-1:0]            slave_wdata;
  logic [DATA_WIDTH/8-1:0]          slave_wstrb;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata;
  logic [NUM_SLAVES-1:0]            slave_ready;

  modport slave (
    input  master_valid, master_instr, master_addr, master_wdata, master_wstrb,
    output master_rdata, master_ready, master_error, master_busy, overflow,
    output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    input  slave_rdata, slave_ready
  );

  modport master (
    output master_valid, master_instr, master_addr, master_wdata, master_wstrb,
    input  master_rdata, master_ready, master_error, master_busy, overflow,
    input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    output slave_rdata, slave_ready
  );
endinterface

// File: rtl/mem_router.sv
// mem_router: routes requests from one master port to NUM_SLAVES slaves.
// Each request is decoded against per-slave [base, top) windows (lowest
// index wins), rebased and issued to one slave; a single transaction is
// tracked, only the addressed slave's ready is honoured, and unmapped
// addresses or timeouts produce an error response. A one-entry skid buffer
// absorbs a request arriving while a transaction is in flight.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus           mem_router_if.slave (master and slave bus signals)
// Optional (macro MEM_ROUTER_STATS_EN):
//   req_count     per-slave issued-request counters, NUM_SLAVES*32 bits
//   err_count     decode errors plus timeouts
//   drop_count    dropped requests
module mem_router #(
  parameter int unsigned                     NUM_SLAVES     = 4,
  parameter int unsigned                     ADDR_WIDTH     = 32,
  parameter int unsigned                     DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_TOP     = '0,
  parameter int unsigned                     TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  mem_router_if.slave       bus
`ifdef MEM_ROUTER_STATS_EN
  ,
  output logic [NUM_SLAVES*32-1:0] req_count,
  output logic [31:0]              err_count,
  output logic [31:0]              drop_count
`endif
);
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_WIDTH-1:0] skid_wdata_q, skid_wdata_d;
  logic [STRB_W-1:0]     skid_wstrb_q, skid_wstrb_d;
  logic                  overflow_q, overflow_d;

  logic                  src_valid, src_instr;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [DATA_WIDTH-1:0] src_wdata;
  logic [STRB_W-1:0]     src_wstrb;
  logic                  hit;
  logic [SW-1:0]         hit_idx;
  logic [ADDR_WIDTH-1:0] hit_base;
  logic                  issue, decode_err, timeout, drop;

  // Request source: a buffered request always goes before a new one.
  always_comb begin
    src_valid = skid_valid_q | bus.master_valid;
    src_instr = skid_valid_q ? skid_instr_q : bus.master_instr;
    src_addr  = skid_valid_q ? skid_addr_q  : bus.master_addr;
    src_wdata = skid_valid_q ? skid_wdata_q : bus.master_wdata;
    src_wstrb = skid_valid_q ? skid_wstrb_q : bus.master_wstrb;
  end

  // Address decode, lowest matching index takes priority.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && src_addr >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]
               && src_addr <  SLAVE_TOP[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit      = 1'b1;
        hit_idx  = SW'(i);
        hit_base = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_wdata_d = skid_wdata_q;
    skid_wstrb_d = skid_wstrb_q;
    overflow_d   = overflow_q;
    issue        = 1'b0;
    decode_err   = 1'b0;
    timeout      = 1'b0;
    drop         = 1'b0;

    bus.slave_valid  = '0;
    bus.slave_instr  = src_instr;
    bus.slave_addr   = src_addr - hit_base;
    bus.slave_wdata  = src_wdata;
    bus.slave_wstrb  = src_wstrb;
    bus.master_ready = 1'b0;
    bus.master_error = 1'b0;
    bus.master_rdata = '0;
    bus.master_busy  = skid_valid_q;
    bus.overflow     = overflow_q;

    case (state_q)
      IDLE: begin
        if (src_valid) begin
          if (hit) begin
            bus.slave_valid[hit_idx] = 1'b1;
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = WAIT;
            issue   = 1'b1;
          end else begin
            state_d    = ERR;
            decode_err = 1'b1;
          end
          // Buffer drains this cycle; refill it with any new request.
          if (skid_valid_q) begin
            skid_valid_d = bus.master_valid;
            if (bus.master_valid) begin
              skid_instr_d = bus.master_instr;
              skid_addr_d  = bus.master_addr;
              skid_wdata_d = bus.master_wdata;
              skid_wstrb_d = bus.master_wstrb;
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.slave_ready[sel_q]) begin
          bus.master_ready = 1'b1;
          bus.master_rdata = bus.slave_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
          state_d          = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // cnt_q counts completed wait cycles, so this is wait cycle TIMEOUT_CYCLES.
          bus.master_ready = 1'b1;
          bus.master_error = 1'b1;
          state_d          = IDLE;
          timeout          = 1'b1;
        end
      end
      ERR: begin
        bus.master_ready = 1'b1;
        bus.master_error = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.master_valid) begin
      if (!skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus.master_instr;
        skid_addr_d  = bus.master_addr;
        skid_wdata_d = bus.master_wdata;
        skid_wstrb_d = bus.master_wstrb;
      end else begin
        overflow_d = 1'b1;
        drop       = 1'b1;
      end
    end

    // Nothing reaches a slave or the master while reset is held.
    if (reset) begin
      bus.slave_valid  = '0;
      bus.master_ready = 1'b0;
      bus.master_error = 1'b0;
      bus.master_rdata = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_wdata_q <= '0;
      skid_wstrb_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_wdata_q <= skid_wdata_d;
      skid_wstrb_q <= skid_wstrb_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef MEM_ROUTER_STATS_EN
  logic [31:0] req_count_q [NUM_SLAVES];
  logic [31:0] req_count_d [NUM_SLAVES];
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_count_d[i] = req_count_q[i] + ((issue && hit_idx == SW'(i)) ? 32'd1 : 32'd0);
      req_count[i*32 +: 32] = req_count_q[i];
    end
    err_count_d  = err_count_q + ((decode_err || timeout) ? 32'd1 : 32'd0);
    drop_count_d = drop_count_q + (drop ? 32'd1 : 32'd0);
    err_count    = err_count_q;
    drop_count   = drop_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) req_count_q[i] <= '0;
      err_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) req_count_q[i] <= req_count_d[i];
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif
endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised memory-bus router connecting one master port (the arbiter output) to NUM_SLAVES slave devices such as rom, print, clint and bram.
- Decodes each request against per-slave base/top windows, rebases the address and forwards the request to exactly one slave.
- Tracks the single outstanding transaction, accepts a ready only from the slave actually addressed, and returns an error response for unmapped addresses or timeouts.
- Holds one early request in a skid buffer so the master can issue back-to-back requests.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8 bits
- SLAVE_BASE, all 0, flattened NUM_SLAVES*ADDR_WIDTH vector; slice i is the base address of slave i
- SLAVE_TOP, all 0, flattened vector; slice i is the exclusive top address of slave i
- TIMEOUT_CYCLES, 255, maximum wait cycles before an error response (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- master_valid  in  1  request strobe, one cycle per request
- master_instr  in  1  instruction-fetch flag
- master_addr  in  ADDR_WIDTH  absolute address
- master_wdata  in  DATA_WIDTH  write data
- master_wstrb  in  DATA_WIDTH/8  byte strobes; 0 means read
- master_rdata  out  DATA_WIDTH  response data
- master_ready  out  1  response strobe
- master_error  out  1  qualifies master_ready; high on decode error or timeout
- master_busy  out  1  skid buffer full
- overflow  out  1  sticky; set when a request is dropped
- slave_valid  out  NUM_SLAVES  one-hot request strobes
- slave_instr  out  1  shared
- slave_addr  out  ADDR_WIDTH  shared; address minus the selected base
- slave_wdata  out  DATA_WIDTH  shared
- slave_wstrb  out  DATA_WIDTH/8  shared
- slave_rdata  in  NUM_SLAVES*DATA_WIDTH  flattened response data
- slave_ready  in  NUM_SLAVES  response strobes

Behaviour:
- Decode: slave i hits when base_i <= addr < top_i (unsigned). The lowest hitting index wins. No hit means a decode error.
- Reset: state IDLE; slave_valid=0, master_ready=0, master_error=0, master_rdata=0, master_busy=0, overflow=0; skid buffer and timeout counter cleared.
- A request issued while reset is high is discarded; no response is produced.
- IDLE state:
  - The request source is the skid buffer if it is valid, else master_valid.
  - On a hit: drive slave_valid[i] combinationally in the same cycle with rebased address, instr, wdata and wstrb; latch index i; clear the timeout counter; go to WAIT.
  - On a miss: go to ERR.
  - If the skid buffer issues and master_valid is also high, capture master_valid into the buffer in the same cycle.
- WAIT state:
  - Only slave_ready[sel] is honoured. When it arrives: master_ready=1, master_rdata=slave_rdata[sel], master_error=0, all combinational that cycle; go to IDLE.
  - Ready from any other slave is ignored.
  - The counter increments each WAIT cycle. If it equals TIMEOUT_CYCLES without a ready: master_ready=1, master_error=1, rdata=0; go to IDLE.
  - A late ready after a timeout is ignored while in IDLE. If it arrives during a later WAIT on the same slave, it is accepted; this is a known limitation.
- ERR state: one cycle with master_ready=1, master_error=1, rdata=0; go to IDLE. Decode-error latency is exactly 1 cycle.
- Requests in WAIT or ERR:
  - master_valid in WAIT or ERR, including the response cycle, is captured into the skid buffer if it is empty.
  - If the buffer is full, the request is dropped and overflow is set.
  - master_busy equals the buffer-valid flag.
- No slave_valid is asserted outside the issuing cycle. At most one bit of slave_valid is ever high.

Optional Feature:
- MEM_ROUTER_STATS_EN defined: adds output ports req_count (NUM_SLAVES*32 bits, per-slave issued-request counters), err_count (32 bits, decode errors plus timeouts) and drop_count (32 bits). All counters wrap at 2^32 and clear on reset.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Windows {0x0-0x1000, 0x2000000-0x200C000, 0x1000000-0x1000004, 0x80000000-0x80100000}; read 0x80000010 -> slave_valid=4'b1000, slave_addr=0x10; slave ready after 3 cycles with 0xDEADBEEF -> master_ready=1, rdata 0xDEADBEEF, error=0.
- Read 0x40000000 (unmapped) -> no slave_valid; master_ready and error=1 one cycle later, rdata=0.
- TIMEOUT_CYCLES=8, slave 0 never responds -> master_ready with error=1 on wait cycle 8; a later slave_ready[0] while IDLE produces no response.
- Request to slave 3 pending; slave_ready[1] pulses -> ignored, master_ready stays 0 until slave_ready[3].
- Three back-to-back master_valid cycles to slave 2 with 2-cycle slave latency -> first issued, second buffered (master_busy=1), third dropped (overflow=1); second issued the cycle after the first response.
- Reset asserted mid-WAIT -> next cycle all outputs 0 and state IDLE; a fresh request then issues normally.
